sort_datapath: RTL

//  Datapath for the in-place K-entry sorter. Executes the controller's strobes
//  (EA EB Li Ei Lj Ej Csel WE Bout) and returns status to the controller (AgtB zi zj).

---
 rtl/sort_pkg.sv | 27 ++
 rtl/sort_mem.sv | 34 +++
 rtl/sort_datapath.sv | 114 +++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the in-place K-entry sorter.
// Holds the default sizes, the index/word types and the controller state
// enum used by the controller, the datapath and the benches.
package sort_pkg;

    localparam int K_DEF  = 8;
    localparam int W_DEF  = 8;
    localparam int AW_DEF = $clog2(K_DEF);

    typedef logic [AW_DEF-1:0] idx_t;
    typedef logic [W_DEF-1:0]  word_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD_J,
        ST_READ_A,
        ST_READ_B,
        ST_CMP,
        ST_SWAP_I,
        ST_SWAP_J,
        ST_NEXT_J,
        ST_NEXT_I,
        ST_DONE
    } sort_state_t;

endpackage

// File: rtl/sort_mem.sv
// K x W register file for the sorter.
// One asynchronous read port and one synchronous write port sharing one address.
// Contents are deliberately not reset.
// Ports:
//   clk    rising-edge clock
//   addr   read/write address
//   we     write strobe
//   wdata  write data
//   rdata  mem[addr], combinational
module sort_mem
    import sort_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int W  = W_DEF,
    parameter int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [K];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sort_datapath.sv
// Datapath of the in-place K-entry sorter.
// Executes controller strobes on the word memory, the i/j index counters and
// the A/B operand registers, and reports AgtB/zi/zj back to the controller.
// An external port owns the memory address while ext_en is high.
// Configuration macro: SORT_DESCEND_EN (defined: AgtB = A < B, descending sort;
// undefined: AgtB = A > B, ascending sort).
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   EA, EB              load A/B from mem[addr]
//   Li, Ei, Lj, Ej      i <= 0, i <= i+1, j <= i+1, j <= j+1
//   Csel                internal address select (0 = i, 1 = j)
//   WE, Bout            internal write, write-data select (1 = B, 0 = A)
//   ext_en, ext_we      external address ownership and write strobe
//   ext_addr, ext_wdata external address and write data
//   ext_rdata           mem[addr], combinational
//   AgtB, zi, zj        compare result, i == K-2, j == K-1
module sort_datapath
    import sort_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int W  = W_DEF,
    parameter int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          EA,
    input  logic          EB,
    input  logic          Li,
    input  logic          Ei,
    input  logic          Lj,
    input  logic          Ej,
    input  logic          Csel,
    input  logic          WE,
    input  logic          Bout,
    input  logic          ext_en,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [W-1:0]  ext_wdata,
    output logic [W-1:0]  ext_rdata,
    output logic          AgtB,
    output logic          zi,
    output logic          zj
);

    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic [AW-1:0] i_inc;
    logic [AW-1:0] j_inc;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [AW-1:0] addr;
    logic          mem_we;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  rdata;

    // Explicit wrap so K need not be a power of two.
    assign i_inc = (i == AW'(K - 1)) ? '0 : i + 1'b1;
    assign j_inc = (j == AW'(K - 1)) ? '0 : j + 1'b1;

    assign addr      = ext_en ? ext_addr : (Csel ? j : i);
    assign mem_we    = ext_en ? ext_we : WE;
    assign mem_wdata = ext_en ? ext_wdata : (Bout ? op_b : op_a);

    sort_mem #(
        .K  (K),
        .W  (W),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .addr  (addr),
        .we    (mem_we),
        .wdata (mem_wdata),
        .rdata (rdata)
    );

    assign ext_rdata = rdata;

    // Lj uses the pre-edge i, so Ei and Lj together give j = old_i + 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i    <= '0;
            j    <= '0;
            op_a <= '0;
            op_b <= '0;
        end else begin
            if (Li) begin
                i <= '0;
            end else if (Ei) begin
                i <= i_inc;
            end
            if (Lj) begin
                j <= i_inc;
            end else if (Ej) begin
                j <= j_inc;
            end
            if (EA) begin
                op_a <= rdata;
            end
            if (EB) begin
                op_b <= rdata;
            end
        end
    end

`ifdef SORT_DESCEND_EN
    assign AgtB = (op_a < op_b);
`else
    assign AgtB = (op_a > op_b);
`endif

    assign zi = (i == AW'(K - 2));
    assign zj = (j == AW'(K - 1));

endmodule
